// File: rtl/atc_pkg.sv
// atc_pkg: shared response codes, direction type and sequencer state encoding
package atc_pkg;
   localparam logic [3:0] SIG_RUNWAY_A = 4'b1010;
   localparam logic [3:0] SIG_RUNWAY_B = 4'b1011;
   localparam logic [3:0] SIG_HOLD     = 4'b1101;
   typedef logic [1:0] dir_t;
   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DECODE, ST_BACKOFF} seq_state_t;
endpackage

// File: rtl/approach_fifo.sv
// approach_fifo: DEPTH-entry queue of arrival directions
// Ports: push/push_data write at the tail, pop advances the head, head is the
// oldest entry, level/full/empty are registered occupancy flags.
module approach_fifo
   import atc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  dir_t                     push_data,
   input  logic                     pop,
   output dir_t                     head,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   dir_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          full_q, full_d, empty_q, empty_d, push_ok, pop_ok;
   always_comb begin
      push_ok  = push && !full_q;
      pop_ok   = pop && !empty_q;
      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      full_d   = level_d == (AW+1)'(DEPTH);
      empty_d  = level_d == '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end
   assign head  = mem_q[rd_ptr_q];
   assign level = level_q;
   assign full  = full_q;
   assign empty = empty_q;
endmodule

// File: rtl/approach_sequencer.sv
// approach_sequencer: queues arrivals and issues one runway request at a time
// Ports: arr_* arrival push interface; req_dir/req_en drive the controller,
// whose signal response is decoded into grant_* pulses, proto_err or divert;
// queue_level reports occupancy. Define APPROACH_RETRY_LIMIT_EN to divert an
// aircraft after MAX_RETRIES holds.
module approach_sequencer
   import atc_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int RESP_WAIT   = 2,
   parameter int HOLD_CYCLES = 8,
   parameter int MAX_RETRIES = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     arr_valid,
   input  logic [1:0]               arr_dir,
   output logic                     arr_ready,
   output logic [1:0]               req_dir,
   output logic                     req_en,
   input  logic [3:0]               signal,
   output logic                     grant_valid,
   output logic                     grant_runway,
   output logic [1:0]               grant_dir,
   output logic                     proto_err,
   output logic                     divert,
   output logic [$clog2(DEPTH):0]   queue_level
);
   localparam int CMAX = RESP_WAIT > HOLD_CYCLES ? RESP_WAIT : HOLD_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int RW   = $clog2(MAX_RETRIES + 2);
   seq_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] retry_q, retry_d;
   dir_t          req_dir_q, req_dir_d, grant_dir_q, grant_dir_d, head;
   logic          req_en_q, req_en_d, grant_valid_q, grant_valid_d;
   logic          grant_runway_q, grant_runway_d, proto_err_q, proto_err_d;
   logic          divert_q, divert_d, pop, full, empty;
   approach_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (arr_valid && !full),
      .push_data (arr_dir),
      .pop       (pop),
      .head      (head),
      .level     (queue_level),
      .full      (full),
      .empty     (empty)
   );
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      retry_d        = retry_q;
      req_dir_d      = req_dir_q;
      req_en_d       = 1'b0;
      grant_valid_d  = 1'b0;
      grant_runway_d = grant_runway_q;
      grant_dir_d    = grant_dir_q;
      proto_err_d    = 1'b0;
      divert_d       = 1'b0;
      pop            = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               state_d   = ST_REQ;
               req_en_d  = 1'b1;
               req_dir_d = head;
            end
         end
         ST_REQ: begin
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
         ST_WAIT: begin
            state_d = cnt_q == CW'(RESP_WAIT - 1) ? ST_DECODE : ST_WAIT;
            cnt_d   = cnt_q + CW'(1);
         end
         ST_DECODE: begin
            cnt_d = '0;
            if (signal == SIG_RUNWAY_A || signal == SIG_RUNWAY_B) begin
               pop            = 1'b1;
               retry_d        = '0;
               grant_valid_d  = 1'b1;
               grant_runway_d = signal == SIG_RUNWAY_B;
               grant_dir_d    = req_dir_q;
               state_d        = ST_IDLE;
            end else if (signal == SIG_HOLD) begin
               // saturate so the count never wraps when holds are unlimited
               retry_d = retry_q == RW'(MAX_RETRIES) ? retry_q : retry_q + RW'(1);
               state_d = ST_BACKOFF;
`ifdef APPROACH_RETRY_LIMIT_EN
               if (retry_q == RW'(MAX_RETRIES)) begin
                  pop      = 1'b1;
                  retry_d  = '0;
                  divert_d = 1'b1;
                  state_d  = ST_IDLE;
               end
`endif
            end else begin
               proto_err_d = 1'b1;
               state_d     = ST_BACKOFF;
            end
         end
         ST_BACKOFF: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
               state_d   = ST_REQ;
               req_en_d  = 1'b1;
               req_dir_d = head;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         retry_q        <= '0;
         req_dir_q      <= '0;
         req_en_q       <= 1'b0;
         grant_valid_q  <= 1'b0;
         grant_runway_q <= 1'b0;
         grant_dir_q    <= '0;
         proto_err_q    <= 1'b0;
         divert_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         retry_q        <= retry_d;
         req_dir_q      <= req_dir_d;
         req_en_q       <= req_en_d;
         grant_valid_q  <= grant_valid_d;
         grant_runway_q <= grant_runway_d;
         grant_dir_q    <= grant_dir_d;
         proto_err_q    <= proto_err_d;
         divert_q       <= divert_d;
      end
   end
   assign arr_ready    = !full;
   assign req_dir      = req_dir_q;
   assign req_en       = req_en_q;
   assign grant_valid  = grant_valid_q;
   assign grant_runway = grant_runway_q;
   assign grant_dir    = grant_dir_q;
   assign proto_err    = proto_err_q;
   assign divert       = divert_q;
endmodule
